// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and load results into one in-order FIFO that feeds
// the register file write port, with a pending-register mask and youngest-value bypass.
module wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_rd,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    w_en,
    output logic [ADDR_W-1:0]       reg_d,
    output logic [DATA_W-1:0]       w_data,
    output logic [(2**ADDR_W)-1:0]  pending_mask,
    input  logic [ADDR_W-1:0]       byp_reg,
    output logic                    byp_hit,
    output logic [DATA_W-1:0]       byp_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  ld_wptr;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              w_en_q;
    logic [ADDR_W-1:0] reg_d_q;
    logic [DATA_W-1:0] w_data_q;

    logic              alu_push;
    logic              ld_push;
    logic              pop;

    // The load side stops one slot early so that a dual push can never overflow.
    assign alu_ready = (count_q <= CNT_W'(DEPTH - 1));
    assign ld_ready  = (count_q <= CNT_W'(DEPTH - 2));
    assign alu_push  = alu_valid & alu_ready;
    assign ld_push   = ld_valid & ld_ready;
    assign pop       = (count_q != '0);

    always_comb begin
        ld_wptr = wptr_q + PTR_W'(alu_push);
        wptr_d  = wptr_q + PTR_W'(alu_push) + PTR_W'(ld_push);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
    end

    // Storage is not reset; only slots covered by count are ever considered valid.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            rd_mem_q[wptr_q]   <= alu_rd;
            data_mem_q[wptr_q] <= alu_data;
        end
        if (ld_push) begin
            rd_mem_q[ld_wptr]   <= ld_rd;
            data_mem_q[ld_wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q   <= 1'b0;
            reg_d_q  <= '0;
            w_data_q <= '0;
        end else if (pop) begin
            w_en_q   <= 1'b1;
            reg_d_q  <= rd_mem_q[rptr_q];
            w_data_q <= data_mem_q[rptr_q];
        end else begin
            w_en_q   <= 1'b0;
        end
    end

    assign w_en   = w_en_q;
    assign reg_d  = reg_d_q;
    assign w_data = w_data_q;

    // Walk oldest to youngest after the output stage so later matches override earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = rptr_q;
        pending_mask = '0;
        byp_hit      = 1'b0;
        byp_data     = '0;
        if (w_en_q) begin
            pending_mask[reg_d_q] = 1'b1;
            if (reg_d_q == byp_reg) begin
                byp_hit  = 1'b1;
                byp_data = w_data_q;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                pending_mask[rd_mem_q[idx]] = 1'b1;
                if (rd_mem_q[idx] == byp_reg) begin
                    byp_hit  = 1'b1;
                    byp_data = data_mem_q[idx];
                end
            end
        end
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue that drives the register file's single write port (`w_en`, `reg_d`, `w_data`).
- Accepts results from the ALU and the load unit over valid/ready handshakes and buffers them in order in one shared FIFO.
- Retires one result per cycle to the register file.
- Exposes a pending-register mask and a bypass lookup so the issue stage can detect hazards and forward queued values.

## Interface
- `DATA_W`, 32, result/register data width
- `ADDR_W`, 4, register index width (16 registers)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  — clock; all state changes on its rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `alu_valid`  in  1  — ALU result offered.
- `alu_ready`  out  1  — ALU result will be accepted.
- `alu_rd`  in  ADDR_W  — ALU destination register.
- `alu_data`  in  DATA_W  — ALU result.
- `ld_valid`  in  1  — load result offered.
- `ld_ready`  out  1  — load result will be accepted.
- `ld_rd`  in  ADDR_W  — load destination register.
- `ld_data`  in  DATA_W  — load data.
- `w_en`  out  1  — register file write enable (registered).
- `reg_d`  out  ADDR_W  — register file write index (registered).
- `w_data`  out  DATA_W  — register file write data (registered).
- `pending_mask`  out  2^ADDR_W  — bit r set while a result for register r is queued or being written.
- `byp_reg`  in  ADDR_W  — bypass lookup register.
- `byp_hit`  out  1  — `byp_reg` has a queued or in-flight result.
- `byp_data`  out  DATA_W  — youngest such result; 0 when no hit.

## Operation
State:
- FIFO of DEPTH entries {rd, data}, with write pointer, read pointer and `count` (0..DEPTH).
- Output stage registers `w_en`, `reg_d`, `w_data`.

Ready:
- Both ready signals are functions of registered `count` only; there is no combinational path from valid to ready.
- `alu_ready` = (`count` ≤ DEPTH-1).
- `ld_ready` = (`count` ≤ DEPTH-2). The load side can never take the last slot. This is intentional, so simultaneous pushes never overflow.
- A transfer occurs when valid && ready is high at the clock edge.

Push order:
- If both sides transfer in the same cycle, the ALU entry is written first (older) and the load entry second.
- `count` increases by the number pushed minus the number popped.

Pop:
- Each edge with `count` > 0 at the start of the cycle pops the head into the output stage: `w_en`=1, `reg_d`=rd, `w_data`=data.
- With `count` = 0: `w_en`=0; `reg_d` and `w_data` hold their previous values.
- A push and a pop in the same cycle are both performed. A pop never consumes an entry pushed in the same cycle.

Pointers:
- Both pointers wrap modulo DEPTH.
- `count` never exceeds DEPTH and never goes below 0.

`pending_mask`:
- Combinational OR of a one-hot of rd over all valid FIFO entries, plus the one-hot of `reg_d` when `w_en`=1.

Bypass:
- Combinational search for `byp_reg` over valid FIFO entries, youngest first, then the output stage if `w_en`=1.
- `byp_data` is the first match; otherwise `byp_hit`=0 and `byp_data`=0.
- Same-register duplicates are legal; the youngest value always wins.

Reset:
- `rst_n` low immediately forces: pointers=0, `count`=0, `w_en`=0, `reg_d`=0, `w_data`=0.
- Consequently `alu_ready`=1, `ld_ready`=1 (DEPTH ≥ 2), `pending_mask`=0, `byp_hit`=0.
- Reset asserted mid-operation discards all queued entries; no write is issued for them.

## Timing
- Latency: a result accepted at edge k into an empty queue appears with `w_en`=1 after edge k+1. The register file captures it during that cycle.
- Throughput: one writeback per cycle sustained. Accepts up to two results per cycle while space allows.
- Entries retire strictly in FIFO order.
- `pending_mask` and `byp_*` reflect state after the most recent edge. They do not include same-cycle inputs.
- After a full drain, `w_en` falls on the edge following the last pop.

## Test plan
- Reset then ALU push rd=5, data=0xDEADBEEF at edge 1 → after edge 2: `w_en`=1, `reg_d`=5, `w_data`=0xDEADBEEF, `pending_mask`[5]=1; after edge 3: `w_en`=0, mask=0.
- Simultaneous ALU rd=1 data=0x11 and load rd=2 data=0x22 into an empty queue → writes appear in order: rd=1 then rd=2 on consecutive cycles.
- Hold `alu_valid`=1 with a fresh rd each cycle, plus `ld_valid`=1, DEPTH=4 → `count` never exceeds 4; `ld_ready`=0 whenever `count` ≥ 3; no entry is lost or duplicated (scoreboard compare).
- Queue rd=7 with 0xA, then rd=7 with 0xB; set `byp_reg`=7 → `byp_hit`=1, `byp_data`=0xB; `byp_reg`=3 → `byp_hit`=0, `byp_data`=0.
- Fill with 3 entries, pulse `rst_n` low asynchronously mid-cycle → outputs return to reset values immediately; no `w_en` pulse after release.
- 200 cycles of random valid on both sides with pointer wrap-around exercised → every accepted result is written exactly once, in acceptance order.
